// File: rtl/periph_port_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave plug among NB_MASTERS.
// Optional response timeout: define PERIPH_ARB_TIMEOUT_EN.
module periph_port_rr_arbiter #(
  parameter int NB_MASTERS     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = $clog2(NB_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NB_MASTERS-1:0]            req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i,
  input  logic [NB_MASTERS-1:0]            wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NB_MASTERS*BE_WIDTH-1:0]   be_i,
  output logic [NB_MASTERS-1:0]            gnt_o,
  output logic [NB_MASTERS-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]            r_rdata_o,
  output logic                             r_opc_o,
  output logic                             per_req_o,
  output logic [ADDR_WIDTH-1:0]            per_add_o,
  output logic                             per_wen_o,
  output logic [DATA_WIDTH-1:0]            per_wdata_o,
  output logic [BE_WIDTH-1:0]              per_be_o,
  output logic [ID_WIDTH-1:0]              per_id_o,
  input  logic                             per_gnt_i,
  input  logic                             per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            per_r_rdata_i,
  input  logic                             per_r_opc_i,
  output logic                             busy_o,
  output logic [7:0]                       late_cnt_o
);

  localparam int PW = (ID_WIDTH < 1) ? 1 : ID_WIDTH;
  localparam logic [DATA_WIDTH-1:0] TO_DATA =
    DATA_WIDTH'(32'hBADACCE5);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] id_q;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic [PW-1:0] next_ptr;
  logic          found;
  logic          issue_ok;
  logic          handshake;
  logic          resp;
  logic          timeout;

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NB_MASTERS);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_ptr = (int'(winner) == NB_MASTERS - 1) ?
                    '0 : winner + PW'(1);

  // A new issue is allowed when idle or in the cycle the reply lands.
  assign issue_ok = !rst_i &&
                    ((state_q == S_IDLE) ||
                     (state_q == S_WAIT && per_r_valid_i));
  assign handshake = per_req_o && per_gnt_i;
  assign resp = !rst_i && (state_q == S_WAIT) &&
                (per_r_valid_i || timeout);
  assign busy_o = (state_q == S_WAIT);

  always_comb begin
    per_req_o   = 1'b0;
    per_add_o   = '0;
    per_wen_o   = 1'b0;
    per_wdata_o = '0;
    per_be_o    = '0;
    per_id_o    = '0;
    gnt_o       = '0;
    if (issue_ok && found) begin
      per_req_o   = 1'b1;
      per_add_o   = add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      per_wen_o   = wen_i[winner];
      per_wdata_o = wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      per_be_o    = be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
      per_id_o    = ID_WIDTH'(winner);
      gnt_o[winner] = per_gnt_i;
    end
  end

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    if (resp) begin
      r_valid_o[id_q] = 1'b1;
      r_rdata_o = per_r_valid_i ? per_r_rdata_i : TO_DATA;
      r_opc_o   = per_r_valid_i ? per_r_opc_i : 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (handshake) state_d = S_WAIT;
      S_WAIT: begin
        if (per_r_valid_i)
          state_d = handshake ? S_WAIT : S_IDLE;
        else if (timeout)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      late_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        id_q   <= winner;
        rr_ptr <= next_ptr;
      end
      if (state_q == S_IDLE && per_r_valid_i && late_cnt_o != 8'hFF)
        late_cnt_o <= late_cnt_o + 8'd1;
    end
  end

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      to_cnt <= '0;
    else if (handshake)
      to_cnt <= '0;
    else if (state_q == S_WAIT && !per_r_valid_i)
      to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = (state_q == S_WAIT) && !per_r_valid_i &&
                   (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/periph_port_rr_arbiter.md
Name: periph_port_rr_arbiter

Overview:
- Shares one cluster peripheral slave plug (EOC, timer, event unit, icache ctrl, DMA or ext) among NB_MASTERS requesters.
- Round-robin arbitration, one outstanding transaction at a time.
- Routes each response back to the requester that issued it.
- Sits between the core-side peripheral interconnect demux and a single speripheral plug.

Parameters:
- NB_MASTERS, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; BE_WIDTH = DATA_WIDTH/8.
- ID_WIDTH, $clog2(NB_MASTERS), width of the granted-master ID.
- TIMEOUT_CYCLES, 256, response timeout in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NB_MASTERS  per-master request.
- add_i  in  NB_MASTERS*ADDR_WIDTH  per-master address.
- wen_i  in  NB_MASTERS  per-master write-enable; 1 = read, 0 = write.
- wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data.
- be_i  in  NB_MASTERS*BE_WIDTH  per-master byte enables.
- gnt_o  out  NB_MASTERS  per-master grant.
- r_valid_o  out  NB_MASTERS  per-master response valid.
- r_rdata_o  out  DATA_WIDTH  response data, shared by all masters.
- r_opc_o  out  1  response error flag, shared by all masters.
- per_req_o  out  1  request to the plug.
- per_add_o  out  ADDR_WIDTH  address to the plug.
- per_wen_o  out  1  write-enable to the plug.
- per_wdata_o  out  DATA_WIDTH  write data to the plug.
- per_be_o  out  BE_WIDTH  byte enables to the plug.
- per_id_o  out  ID_WIDTH  granted-master ID.
- per_gnt_i  in  1  grant from the plug.
- per_r_valid_i  in  1  response valid from the plug.
- per_r_rdata_i  in  DATA_WIDTH  response data from the plug.
- per_r_opc_i  in  1  response error from the plug.
- busy_o  out  1  high while in WAIT.
- late_cnt_o  out  8  count of dropped late responses.

Behaviour:
- Reset: all outputs are 0. State is IDLE, rr_ptr is 0, id_q is 0, late_cnt_o is 0.
- Arbitration is combinational. The winner is the first requesting master found scanning from rr_ptr upward, modulo NB_MASTERS.
- IDLE:
  - If any req_i is set, per_req_o = 1 and the per_* request fields mux the winner's signals; per_id_o = winner.
  - gnt_o[winner] = per_gnt_i; all other gnt_o bits are 0.
  - On per_req_o && per_gnt_i: id_q <= winner, rr_ptr <= (winner+1) mod NB_MASTERS, next state WAIT.
- WAIT:
  - per_req_o = 0 and every gnt_o bit is 0, except in the response cycle below.
  - When per_r_valid_i = 1, in the same cycle: r_valid_o[id_q] = 1, r_rdata_o = per_r_rdata_i, r_opc_o = per_r_opc_i.
  - In that same response cycle, arbitration runs as in IDLE (back-to-back issue). On a new handshake the block stays in WAIT with the new id_q; otherwise it returns to IDLE.
- Response latency is 0 cycles from the plug; the arbiter adds no pipeline stage. Issue-to-issue throughput is 1 transaction per plug round trip.
- A master that drops req_i before grant loses nothing. rr_ptr advances only on a handshake.
- NB_MASTERS = 1: rr_ptr stays 0.
- per_r_valid_i in IDLE is a stray response:
  - It is ignored; r_valid_o stays 0.
  - late_cnt_o increments and saturates at 255.
- Between responses, r_rdata_o and r_opc_o are 0.
- Reset mid-transaction: the block returns to IDLE and abandons the outstanding response. A response that arrives after reset counts as late.

Optional Feature:
- Macro: PERIPH_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without per_r_valid_i.
  - When the counter reaches TIMEOUT_CYCLES-1 with still no response: r_valid_o[id_q] = 1, r_opc_o = 1, r_rdata_o = 32'hBADACCE5 (truncated or zero-extended to DATA_WIDTH), next state IDLE.
  - No new grant is issued in the timeout cycle.
  - The eventual real response counts as late.
- When undefined: no counter is present and WAIT lasts indefinitely.

Test Plan:
- All 4 masters hold req_i, per_gnt_i = 1, plug responds 1 cycle after grant -> grants issue in order 0,1,2,3,0. Each r_valid_o pulses on the matching bit with the plug's rdata.
- Master 2 alone writes add = 0x1020_4000, data = 0xA5A5A5A5, be = 0xF -> per_* fields match exactly, per_id_o = 2, gnt_o = 4'b0100.
- per_gnt_i held 0 for 5 cycles while masters 1 and 3 request -> gnt_o stays 0 and rr_ptr stays put. On grant, master 1 wins.
- Response and a new request from master 0 in the same cycle -> r_valid_o[prev] = 1 and gnt_o[0] = 1 in that cycle. busy_o stays 1.
- per_r_valid_i pulsed 3 times while IDLE -> late_cnt_o = 3, no r_valid_o.
- With PERIPH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no response after grant to master 1 -> r_valid_o[1] = 1, r_opc_o = 1, r_rdata_o = 0xBADACCE5 exactly 8 cycles after the handshake. A later response gives late_cnt_o = 1.
